// File: rtl/ibpl_pkg.sv
// Shared constants and helpers for the LWL input cardlet.
package ibpl_pkg;

  localparam int CH_IDX_W = 4;
  localparam int MAX_CH   = 16;

  // Default physical-pin map, field i (LSB first) = pin feeding logical channel i.
  localparam logic [6*CH_IDX_W-1:0] LWL_MAP6 = {4'd5, 4'd2, 4'd4, 4'd1, 4'd3, 4'd0};

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ibpl_in_filter.sv
// One LWL input channel: polarity fix, 2-FF synchroniser and glitch filter.
module ibpl_in_filter
  import ibpl_pkg::*;
#(
  parameter bit INV      = 1'b0,
  parameter int FILT_CYC = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic filt
);

  logic sync_m;
  logic sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_m <= 1'b0;
      sync   <= 1'b0;
    end else begin
      sync_m <= pin ^ INV;
      sync   <= sync_m;
    end
  end

  generate
    if (FILT_CYC == 0) begin : g_bypass
      assign filt = sync;
    end else begin : g_filter
      localparam int CW = cnt_width(FILT_CYC);
      localparam logic [CW-1:0] LAST = CW'(FILT_CYC - 1);

      logic [CW-1:0] cnt;
      logic          filt_q;

      // A new level is accepted on its FILT_CYC-th consecutive differing sample.
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt    <= '0;
          filt_q <= 1'b0;
        end else if (sync != filt_q) begin
          if (cnt == LAST) begin
            filt_q <= sync;
            cnt    <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end else begin
          cnt <= '0;
        end
      end

      assign filt = filt_q;
    end
  endgenerate

endmodule

// File: rtl/ibpl_lwlin_multi.sv
// Parametrised fibre-optic input cardlet: conditioned inputs, activity LEDs
// and direction-conflict error for the interbackplane frontend.
module ibpl_lwlin_multi
  import ibpl_pkg::*;
#(
  parameter int                        N_CH        = 6,
  parameter int                        INT_W       = 8,
  parameter logic [N_CH*CH_IDX_W-1:0]  CH_MAP      = LWL_MAP6,
  parameter logic [N_CH-1:0]           INV_MASK    = '1,
  parameter int                        FILT_CYC    = 3,
  parameter int                        STRETCH_CYC = 6250000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  diob_in,
  output logic [N_CH-1:0]  diob_dir,
  output logic [N_CH-1:0]  diob_out,
  input  logic [INT_W-1:0] input_enable,
  input  logic [INT_W-1:0] output_enable,
  input  logic [INT_W-1:0] input_act,
  input  logic             err_clr,
  output logic [INT_W-1:0] internal_in,
  output logic [INT_W-1:0] diob_led1,
  output logic [INT_W-1:0] diob_led2,
  output logic             plugin_error,
  output logic             plugin_error_sticky
);

  localparam logic [INT_W-1:0] CH_MASK = INT_W'((1 << N_CH) - 1);
  localparam int               SW      = cnt_width(STRETCH_CYC);
  localparam logic [SW-1:0]    STRETCH_LOAD = SW'(STRETCH_CYC - 1);

  generate
    if (N_CH < 1 || N_CH > INT_W || N_CH > MAX_CH) begin : g_bad_nch
      $error("ibpl_lwlin_multi: N_CH out of range");
    end
    for (genvar i = 0; i < N_CH; i++) begin : g_map_chk
      if (int'(CH_MAP[i*CH_IDX_W +: CH_IDX_W]) >= N_CH) begin : g_range
        $error("ibpl_lwlin_multi: CH_MAP field selects a missing pin");
      end
      for (genvar j = i + 1; j < N_CH; j++) begin : g_dup
        if (CH_MAP[i*CH_IDX_W +: CH_IDX_W] == CH_MAP[j*CH_IDX_W +: CH_IDX_W]) begin : g_err
          $error("ibpl_lwlin_multi: duplicate CH_MAP field");
        end
      end
    end
  endgenerate

  assign diob_dir = '0;
  assign diob_out = '0;

  logic [N_CH-1:0] filt;

  for (genvar p = 0; p < N_CH; p++) begin : g_ch
    ibpl_in_filter #(
      .INV      (INV_MASK[p]),
      .FILT_CYC (FILT_CYC)
    ) u_filt (
      .clk  (clk),
      .rst  (rst),
      .pin  (diob_in[p]),
      .filt (filt[p])
    );
  end

  logic [INT_W-1:0] mapped;

  always_comb begin
    mapped = '0;
    for (int i = 0; i < N_CH; i++) begin
      for (int p = 0; p < N_CH; p++) begin
        if (int'(CH_MAP[i*CH_IDX_W +: CH_IDX_W]) == p) begin
          mapped[i] = filt[p] & input_enable[i];
        end
      end
    end
  end

  logic conflict;
  assign conflict = |(output_enable & ~input_enable & CH_MASK);

  always_ff @(posedge clk) begin
    if (rst) begin
      internal_in         <= '0;
      plugin_error        <= 1'b0;
      plugin_error_sticky <= 1'b0;
    end else begin
      internal_in         <= mapped;
      plugin_error        <= conflict;
      plugin_error_sticky <= conflict | (plugin_error_sticky & ~err_clr);
    end
  end

  logic [N_CH-1:0] act_q;
  logic [SW-1:0]   stretch_cnt [N_CH];

  // Each rising activity edge (re)loads the hold counter; it parks at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_q <= '0;
      for (int i = 0; i < N_CH; i++) stretch_cnt[i] <= '0;
    end else begin
      act_q <= input_act[N_CH-1:0];
      for (int i = 0; i < N_CH; i++) begin
        if (input_act[i] & ~act_q[i]) begin
          stretch_cnt[i] <= STRETCH_LOAD;
        end else if (stretch_cnt[i] != '0) begin
          stretch_cnt[i] <= stretch_cnt[i] - SW'(1);
        end
      end
    end
  end

  logic [INT_W-1:0] stretch_on;

  always_comb begin
    stretch_on = '0;
    for (int i = 0; i < N_CH; i++) stretch_on[i] = (stretch_cnt[i] != '0);
  end

  assign diob_led1 = (input_act & CH_MASK) | stretch_on;
  assign diob_led2 = input_enable & CH_MASK;

endmodule

// File: tb/tb_ibpl_lwlin_multi.sv
// Self-checking bench for ibpl_lwlin_multi with a behavioural reference model.
module tb_ibpl_lwlin_multi;

  localparam int N_CH  = 6;
  localparam int INT_W = 8;
  localparam int FILT  = 3;
  localparam int STR   = 10;
  localparam int LOG_N = 8192;

  logic             clk = 1'b0;
  logic             rst;
  logic [N_CH-1:0]  diob_in;
  logic [N_CH-1:0]  diob_dir;
  logic [N_CH-1:0]  diob_out;
  logic [INT_W-1:0] input_enable;
  logic [INT_W-1:0] output_enable;
  logic [INT_W-1:0] input_act;
  logic             err_clr;
  logic [INT_W-1:0] internal_in;
  logic [INT_W-1:0] diob_led1;
  logic [INT_W-1:0] diob_led2;
  logic             plugin_error;
  logic             plugin_error_sticky;

  always #5 clk = ~clk;

  ibpl_lwlin_multi #(
    .N_CH        (N_CH),
    .INT_W       (INT_W),
    .FILT_CYC    (FILT),
    .STRETCH_CYC (STR)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .diob_in             (diob_in),
    .diob_dir            (diob_dir),
    .diob_out            (diob_out),
    .input_enable        (input_enable),
    .output_enable       (output_enable),
    .input_act           (input_act),
    .err_clr             (err_clr),
    .internal_in         (internal_in),
    .diob_led1           (diob_led1),
    .diob_led2           (diob_led2),
    .plugin_error        (plugin_error),
    .plugin_error_sticky (plugin_error_sticky)
  );

  int total = 0;
  int bad   = 0;

  task automatic check8(input string name, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Reference model: logical channel i is fed by physical pin map_tbl[i].
  int         map_tbl [N_CH] = '{0, 3, 1, 4, 2, 5};
  bit         act_log [N_CH][LOG_N];
  bit         filt_m  [N_CH];
  bit         prev_act[N_CH];
  int         last_rise[N_CH];
  logic [7:0] int_m;
  bit         err_m;
  bit         sticky_m;
  int         ecount;
  int         cyc;

  // Level seen by the filter at post-reset edge j: the pin two edges earlier.
  function automatic bit sync_at(input int p, input int j);
    return (j >= 2) ? act_log[p][j-2] : 1'b0;
  endfunction

  task automatic model_edge();
    logic [7:0] nxt;
    bit         differs;
    bit         conflict;
    if (rst) begin
      ecount   = 0;
      int_m    = '0;
      err_m    = 1'b0;
      sticky_m = 1'b0;
      for (int p = 0; p < N_CH; p++) begin
        filt_m[p]    = 1'b0;
        prev_act[p]  = 1'b0;
        last_rise[p] = -1000;
      end
    end else begin
      nxt = '0;
      for (int i = 0; i < N_CH; i++) nxt[i] = filt_m[map_tbl[i]] & input_enable[i];
      for (int p = 0; p < N_CH; p++) act_log[p][ecount] = ~diob_in[p];
      for (int p = 0; p < N_CH; p++) begin
        differs = 1'b1;
        for (int j = ecount - FILT + 1; j <= ecount; j++) begin
          if (j < 0 || sync_at(p, j) == filt_m[p]) differs = 1'b0;
        end
        if (differs) filt_m[p] = ~filt_m[p];
      end
      int_m    = nxt;
      conflict = |(output_enable[N_CH-1:0] & ~input_enable[N_CH-1:0]);
      err_m    = conflict;
      sticky_m = conflict | (sticky_m & ~err_clr);
      for (int i = 0; i < N_CH; i++) begin
        if (input_act[i] && !prev_act[i]) last_rise[i] = cyc;
        prev_act[i] = input_act[i];
      end
      if (ecount < LOG_N - 1) ecount++;
    end
    cyc++;
  endtask

  task automatic check_model();
    logic [7:0] led_exp;
    led_exp = '0;
    for (int i = 0; i < N_CH; i++) begin
      led_exp[i] = input_act[i] | ((cyc - last_rise[i]) >= 1 && (cyc - last_rise[i]) <= STR - 1);
    end
    check8("m_internal_in", internal_in, int_m);
    check8("m_diob_led1", diob_led1, led_exp);
    check8("m_diob_led2", diob_led2, input_enable & 8'h3F);
    check8("m_plugin_error", {7'd0, plugin_error}, {7'd0, err_m});
    check8("m_sticky", {7'd0, plugin_error_sticky}, {7'd0, sticky_m});
  endtask

  task automatic cycle();
    #1;
    check_model();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic requal(input string tag);
    diob_in = '0;
    input_enable = 8'h3F;
    rst = 1'b1;
    cycle();
    check8({tag, "_rst_int"}, internal_in, 8'h00);
    rst = 1'b0;
    repeat (5) cycle();
    check8({tag, "_int_at5"}, internal_in, 8'h00);
    cycle();
    check8({tag, "_int_at6"}, internal_in, 8'h3F);
  endtask

  typedef struct {
    logic [5:0] act_pins;
    logic [7:0] ie;
    logic [7:0] oe;
    logic [7:0] exp_int;
    bit         exp_err;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   first;
    int   rises;
    int   hits;
    int   last_hi;
    logic prev;
    logic led_s;

    vecs[0] = '{6'b001000, 8'h3F, 8'h00, 8'h02, 1'b0};
    vecs[1] = '{6'b000010, 8'h3F, 8'h00, 8'h04, 1'b0};
    vecs[2] = '{6'b100000, 8'h3F, 8'h00, 8'h20, 1'b0};
    vecs[3] = '{6'b000100, 8'h3F, 8'h00, 8'h10, 1'b0};
    vecs[4] = '{6'b010000, 8'h3F, 8'h00, 8'h08, 1'b0};
    vecs[5] = '{6'b111111, 8'h3F, 8'h00, 8'h3F, 1'b0};
    vecs[6] = '{6'b111111, 8'h15, 8'h00, 8'h15, 1'b0};
    vecs[7] = '{6'b000001, 8'h3F, 8'h01, 8'h01, 1'b0};
    vecs[8] = '{6'b000000, 8'h00, 8'h01, 8'h00, 1'b1};
    vecs[9] = '{6'b100000, 8'h3F, 8'hC0, 8'h20, 1'b0};

    rst = 1'b1; diob_in = '1; input_enable = 8'h3F; output_enable = '0;
    input_act = '0; err_clr = 1'b0; cyc = 0;
    #1;
    model_edge();
    @(posedge clk);
    #1;

    // Reset held with toggling pins, then release with every pin active.
    for (int k = 0; k < 4; k++) begin
      diob_in = N_CH'($urandom);
      cycle();
    end
    check8("rst_internal_in", internal_in, 8'h00);
    check8("rst_diob_led1", diob_led1, 8'h00);
    check8("rst_plugin_error", {7'd0, plugin_error}, 8'h00);
    check8("rst_sticky", {7'd0, plugin_error_sticky}, 8'h00);
    diob_in = '0;
    rst = 1'b0;
    repeat (5) cycle();
    check8("rel_int_at5", internal_in, 8'h00);
    cycle();
    check8("rel_int_at6", internal_in, 8'h3F);

    for (int v = 0; v < 10; v++) begin
      diob_in       = ~vecs[v].act_pins;
      input_enable  = vecs[v].ie;
      output_enable = vecs[v].oe;
      repeat (8) cycle();
      check8($sformatf("tbl%0d_int", v), internal_in, vecs[v].exp_int);
      check8($sformatf("tbl%0d_err", v), {7'd0, plugin_error}, {7'd0, vecs[v].exp_err});
      check8($sformatf("tbl%0d_dir", v), {2'd0, diob_dir}, 8'h00);
      check8($sformatf("tbl%0d_out", v), {2'd0, diob_out}, 8'h00);
    end

    requal("midrst");

    // Glitch filter: short pulses on pin 0.
    diob_in = '1; input_enable = 8'h3F; output_enable = '0;
    repeat (8) cycle();
    hits = 0;
    for (int k = 0; k < 12; k++) begin
      diob_in[0] = (k < 2) ? 1'b0 : 1'b1;
      cycle();
      if (internal_in[0]) hits++;
    end
    check_int("pulse2_hits", hits, 0);
    first = -1; rises = 0; prev = 1'b0;
    for (int k = 0; k < 14; k++) begin
      diob_in[0] = (k < 3) ? 1'b0 : 1'b1;
      cycle();
      if (internal_in[0] && first < 0) first = k + 1;
      if (internal_in[0] && !prev) rises++;
      prev = internal_in[0];
    end
    check_int("pulse3_first", first, 6);
    check_int("pulse3_rises", rises, 1);

    // Activity LED stretch, single trigger then retrigger.
    input_act = '0;
    repeat (12) cycle();
    hits = 0; last_hi = -1;
    for (int k = 0; k < 20; k++) begin
      input_act[2] = (k == 0);
      #1;
      led_s = diob_led1[2];
      if (led_s) begin hits++; last_hi = k; end
      cycle();
    end
    check_int("stretch1_hits", hits, 10);
    check_int("stretch1_last", last_hi, 9);
    hits = 0; last_hi = -1;
    for (int k = 0; k < 25; k++) begin
      input_act[2] = (k == 0 || k == 5);
      #1;
      led_s = diob_led1[2];
      if (led_s) begin hits++; last_hi = k; end
      cycle();
    end
    check_int("stretch2_hits", hits, 15);
    check_int("stretch2_last", last_hi, 14);

    // Error flags.
    input_enable = 8'h3F; output_enable = 8'h00; err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    cycle();
    check8("err_sticky_clr0", {7'd0, plugin_error_sticky}, 8'h00);
    input_enable = 8'h00; output_enable = 8'h01;
    #1;
    check8("err_pre_edge", {7'd0, plugin_error}, 8'h00);
    cycle();
    check8("err_live", {7'd0, plugin_error}, 8'h01);
    check8("err_sticky_set", {7'd0, plugin_error_sticky}, 8'h01);
    output_enable = 8'h00;
    cycle();
    check8("err_live_off", {7'd0, plugin_error}, 8'h00);
    check8("err_sticky_hold", {7'd0, plugin_error_sticky}, 8'h01);
    err_clr = 1'b1;
    cycle();
    check8("err_sticky_clr", {7'd0, plugin_error_sticky}, 8'h00);
    output_enable = 8'h01;
    cycle();
    check8("err_clr_vs_conflict", {7'd0, plugin_error_sticky}, 8'h01);
    err_clr = 1'b0; output_enable = 8'hC0; input_enable = 8'h3F;
    cycle();
    check8("err_upper_bits", {7'd0, plugin_error}, 8'h00);

    // Random traffic against the model.
    for (int k = 0; k < 2500; k++) begin
      for (int p = 0; p < N_CH; p++) begin
        if ($urandom_range(3) == 0) diob_in[p] = ~diob_in[p];
      end
      if ($urandom_range(15) == 0) input_enable = ($urandom_range(1) == 0) ? 8'h3F : 8'($urandom);
      if ($urandom_range(11) == 0) output_enable = ($urandom_range(1) == 0) ? 8'h00 : 8'($urandom);
      for (int i = 0; i < INT_W; i++) begin
        if ($urandom_range(7) == 0) input_act[i] = ~input_act[i];
      end
      err_clr = ($urandom_range(7) == 0);
      rst = ($urandom_range(299) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
